// File: rtl/console_pkg.sv
// Shared definitions for the console I/O controller: byte width,
// RX handshake state encodings and STATUS bit positions.
package console_pkg;

    localparam int BYTE_W = 8;

    // RX handshake states: waiting for a byte, or holding ack until valid drops
    typedef enum logic [0:0] {
        RX_IDLE = 1'b0,
        RX_ACK  = 1'b1
    } rx_state_e;

    // Bit positions inside the 4-bit STATUS word
    localparam int ST_RX_AVAIL = 0;
    localparam int ST_TX_FULL  = 1;
    localparam int ST_RX_OVF   = 2;
    localparam int ST_TX_OVF   = 3;

endpackage

// File: rtl/console_fifo.sv
// Synchronous byte FIFO. Requests that cannot be honoured are ignored:
// a pop on empty does nothing. A push on full is accepted only when a pop
// happens in the same cycle, so the slot being freed is reused.
// The head output reads zero while the FIFO is empty.
module console_fifo
    import console_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [BYTE_W-1:0]        din,
    output logic [BYTE_W-1:0]        head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [BYTE_W-1:0] mem_q [DEPTH];
    logic [BYTE_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push;
    logic              do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign count = count_q;
    assign head  = empty ? '0 : mem_q[rd_ptr_q];

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Next-state for storage, pointers and occupancy; pointers wrap naturally
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Register update; reset flushes the FIFO and clears storage
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/console_io_ctrl.sv
// Console I/O controller: captures UART bytes into an RX FIFO through a
// 4-phase valid/ack handshake, streams processor writes out of a TX FIFO
// over ready/valid, and exposes a pollable status word.
module console_io_ctrl
    import console_pkg::*;
#(
    parameter int RX_DEPTH = 4,
    parameter int TX_DEPTH = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [BYTE_W-1:0] CONSOLE_IN,
    input  logic              CONSOLE_IN_valid,
    output logic              CONSOLE_IN_ack,
    output logic [BYTE_W-1:0] CONSOLE_OUT,
    output logic              CONSOLE_OUT_valid,
    input  logic              CONSOLE_OUT_ready,
    input  logic              RD_req,
    output logic [BYTE_W-1:0] RD_data,
    input  logic              WR_req,
    input  logic [BYTE_W-1:0] WR_data,
    output logic [3:0]        STATUS
);

    localparam int RX_CW = $clog2(RX_DEPTH) + 1;
    localparam int TX_CW = $clog2(TX_DEPTH) + 1;

    rx_state_e         state_q;
    logic              ack_q;
    logic [BYTE_W-1:0] rd_data_q, rd_data_d;
    logic              rx_ovf_q, rx_ovf_d;
    logic              tx_ovf_q, tx_ovf_d;

    logic              rx_push, rx_pop;
    logic [BYTE_W-1:0] rx_head;
    logic              rx_full, rx_empty;
    logic [RX_CW-1:0]  rx_count;

    logic              tx_pop;
    logic              tx_full, tx_empty;
    logic [TX_CW-1:0]  tx_count;

    // A byte is only taken from the UART when there is room; otherwise it waits
    assign rx_push = (state_q == RX_IDLE) && CONSOLE_IN_valid && !rx_full;
    assign rx_pop  = RD_req && !rx_empty;
    assign tx_pop  = !tx_empty && CONSOLE_OUT_ready;

    console_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (CLK),
        .reset (RESET),
        .push  (rx_push),
        .pop   (rx_pop),
        .din   (CONSOLE_IN),
        .head  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    console_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (CLK),
        .reset (RESET),
        .push  (WR_req),
        .pop   (tx_pop),
        .din   (WR_data),
        .head  (CONSOLE_OUT),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    // RX handshake: push once on valid, then hold ack until the UART releases valid
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= RX_IDLE;
            ack_q   <= 1'b0;
        end else begin
            case (state_q)
                RX_IDLE: begin
                    if (CONSOLE_IN_valid && !rx_full) begin
                        state_q <= RX_ACK;
                        ack_q   <= 1'b1;
                    end
                end
                RX_ACK: begin
                    if (!CONSOLE_IN_valid) begin
                        state_q <= RX_IDLE;
                        ack_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= RX_IDLE;
                    ack_q   <= 1'b0;
                end
            endcase
        end
    end

    // Read data and sticky error flags; a read of an empty FIFO returns zero
    always_comb begin
        rd_data_d = rd_data_q;
        rx_ovf_d  = rx_ovf_q;
        tx_ovf_d  = tx_ovf_q;
        if (RD_req) begin
            rd_data_d = rx_empty ? '0 : rx_head;
            if (rx_empty) begin
                rx_ovf_d = 1'b1;
            end
        end
        if (WR_req && (tx_count == TX_CW'(TX_DEPTH)) && !tx_pop) begin
            tx_ovf_d = 1'b1;
        end
    end

    // Register read data and flags; flags only clear on reset
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rd_data_q <= '0;
            rx_ovf_q  <= 1'b0;
            tx_ovf_q  <= 1'b0;
        end else begin
            rd_data_q <= rd_data_d;
            rx_ovf_q  <= rx_ovf_d;
            tx_ovf_q  <= tx_ovf_d;
        end
    end

    assign CONSOLE_IN_ack    = ack_q;
    assign CONSOLE_OUT_valid = !tx_empty;
    assign RD_data           = rd_data_q;

    assign STATUS[ST_RX_AVAIL] = (rx_count != '0);
    assign STATUS[ST_TX_FULL]  = tx_full;
    assign STATUS[ST_RX_OVF]   = rx_ovf_q;
    assign STATUS[ST_TX_OVF]   = tx_ovf_q;

endmodule
